// File: rtl/trivium_pkg.sv
// Shared types and constants for the Trivium keystream sequencer.
package trivium_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWarm,
    StRun
  } state_e;

  localparam int unsigned KS_WORD_W = 32;
  localparam int unsigned KEY_W     = 80;
  localparam int unsigned IV_W      = 80;

  // One-hot load strobes, one per 32-bit slice of key/IV.
  localparam logic [2:0] LD_W0 = 3'b001;
  localparam logic [2:0] LD_W1 = 3'b010;
  localparam logic [2:0] LD_W2 = 3'b100;

  localparam int unsigned LEN_A = 93;
  localparam int unsigned LEN_B = 84;
  localparam int unsigned LEN_C = 111;

  // Load strobe for slice index; index 3 is never reached.
  function automatic logic [2:0] ld_onehot(input logic [1:0] idx);
    logic [2:0] res;
    unique case (idx)
      2'd0:    res = LD_W0;
      2'd1:    res = LD_W1;
      2'd2:    res = LD_W2;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  // LSB-first 32-bit slice of an 80-bit key or IV; the top slice is zero-padded.
  function automatic logic [KS_WORD_W-1:0] word_slice(input logic [KEY_W-1:0] v,
                                                      input logic [1:0]       idx);
    logic [KS_WORD_W-1:0] res;
    unique case (idx)
      2'd0:    res = v[31:0];
      2'd1:    res = v[63:32];
      2'd2:    res = {16'h0, v[79:64]};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/trivium_ks_packer.sv
// Packs keystream bits LSB-first into 32-bit words and holds them behind a valid/ready handshake.
module trivium_ks_packer
  import trivium_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 n_rst_i,
  input  logic                 clr_i,
  input  logic                 run_i,
  input  logic                 bit_vld_i,
  input  logic                 bit_i,
  input  logic                 ks_ready_i,
  output logic                 stall_o,
  output logic [KS_WORD_W-1:0] ks_word_o,
  output logic                 ks_valid_o
);

  logic [KS_WORD_W-1:0] buf_q, buf_d;
  logic [KS_WORD_W-1:0] word_q, word_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 valid_q, valid_d;

  // Stall only on the final bit of a word while the previous word is still pending.
  always_comb begin
    stall_o = run_i & (cnt_q == 5'd31) & valid_q & ~ks_ready_i;
  end

  // Next-state: accept pending word, insert new bit, hand over a completed word.
  always_comb begin
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = valid_q;
    if (clr_i) begin
      buf_d   = '0;
      cnt_d   = '0;
      word_d  = '0;
      valid_d = 1'b0;
    end else begin
      if (valid_q && ks_ready_i) begin
        valid_d = 1'b0;
      end
      if (bit_vld_i) begin
        buf_d[cnt_q] = bit_i;
        cnt_d        = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          // Word includes the bit taken this cycle; overrides the acceptance above.
          word_d  = buf_d;
          valid_d = 1'b1;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign ks_word_o  = word_q;
  assign ks_valid_o = valid_q;

endmodule

// File: rtl/trivium_ctrl.sv
// Trivium sequencer: latches key/IV, loads the A/B/C registers, runs warm-up, then streams
// keystream words.
module trivium_ctrl
  import trivium_pkg::*;
#(
  parameter int unsigned WARMUP_CYC = 1152
) (
  input  logic                 clk_i,
  input  logic                 n_rst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [KEY_W-1:0]     key_i,
  input  logic [IV_W-1:0]      iv_i,
  output logic                 busy_o,
  output logic                 run_o,
  output logic [2:0]           ld_o,
  output logic [31:0]          ld_dat_a_o,
  output logic [31:0]          ld_dat_b_o,
  output logic [31:0]          ld_dat_c_o,
  output logic                 ce_o,
  input  logic                 t_a_i,
  input  logic                 t_b_i,
  input  logic                 t_c_i,
  output logic [KS_WORD_W-1:0] ks_word_o,
  output logic                 ks_valid_o,
  input  logic                 ks_ready_i
);

  localparam logic [10:0] WarmInit = 11'(WARMUP_CYC - 1);

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [10:0]       warm_q, warm_d;
  logic [KEY_W-1:0]  key_q;
  logic [IV_W-1:0]   iv_q;
  logic              latch;
  logic              pk_clr;
  logic              pk_stall;
  logic              in_run;
  logic              bit_vld;
  logic              z;

  // Next-state: start wins over stop, and both override the normal sequence.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    warm_d  = warm_q;
    latch   = 1'b0;
    pk_clr  = 1'b0;
    if (start_i) begin
      state_d = StLoad;
      idx_d   = 2'd0;
      latch   = 1'b1;
      pk_clr  = 1'b1;
    end else if (stop_i) begin
      state_d = StIdle;
      idx_d   = 2'd0;
      warm_d  = '0;
      pk_clr  = 1'b1;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (idx_q == 2'd2) begin
            state_d = StWarm;
            idx_d   = 2'd0;
            warm_d  = WarmInit;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        StWarm: begin
          if (warm_q == '0) begin
            state_d = StRun;
          end else begin
            warm_d = warm_q - 11'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Control registers and key/IV latches.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      warm_q  <= '0;
      key_q   <= '0;
      iv_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      warm_q  <= warm_d;
      if (latch) begin
        key_q <= key_i;
        iv_q  <= iv_i;
      end
    end
  end

  // Decoded outputs; load data is zero outside LOAD so idle ports stay quiet.
  always_comb begin
    busy_o     = 1'b0;
    in_run     = 1'b0;
    ld_o       = '0;
    ld_dat_a_o = '0;
    ld_dat_b_o = '0;
    ld_dat_c_o = '0;
    ce_o       = 1'b0;
    unique case (state_q)
      StLoad: begin
        busy_o     = 1'b1;
        ld_o       = ld_onehot(idx_q);
        ld_dat_a_o = word_slice(key_q, idx_q);
        ld_dat_b_o = word_slice(iv_q, idx_q);
      end
      StWarm: begin
        busy_o = 1'b1;
        ce_o   = 1'b1;
      end
      StRun: begin
        in_run = 1'b1;
        ce_o   = ~pk_stall;
      end
      default: ;
    endcase
  end

  assign run_o   = in_run;
  assign bit_vld = in_run & ~pk_stall;
  // Terms are combinational from the pre-shift register state.
  assign z       = t_a_i ^ t_b_i ^ t_c_i;

  trivium_ks_packer u_packer (
    .clk_i      (clk_i),
    .n_rst_i    (n_rst_i),
    .clr_i      (pk_clr),
    .run_i      (in_run),
    .bit_vld_i  (bit_vld),
    .bit_i      (z),
    .ks_ready_i (ks_ready_i),
    .stall_o    (pk_stall),
    .ks_word_o  (ks_word_o),
    .ks_valid_o (ks_valid_o)
  );

endmodule

// File: tb/tb_trivium_ctrl.sv
// Directed bench for trivium_ctrl with a behavioural Trivium register model and reference.
module tb_trivium_ctrl;

  localparam int unsigned WARM = 1152;

  logic        clk_i = 1'b0;
  logic        n_rst_i;
  logic        start_i, stop_i;
  logic [79:0] key_i, iv_i;
  logic        busy_o, run_o;
  logic [2:0]  ld_o;
  logic [31:0] ld_dat_a_o, ld_dat_b_o, ld_dat_c_o;
  logic        ce_o;
  logic        t_a_i, t_b_i, t_c_i;
  logic [31:0] ks_word_o;
  logic        ks_valid_o, ks_ready_i;

  int n_chk = 0;
  int n_err = 0;
  int cyc;
  logic [31:0]  ref_ks [4];
  logic [287:0] core_s;

  localparam logic [79:0] Key2 = 80'h0123456789ABCDEF0011;
  localparam logic [79:0] Iv2  = 80'hFEDCBA98765432100022;
  localparam logic [79:0] Key3 = 80'hA5A50F0F123456789ABC;
  localparam logic [79:0] Iv3  = 80'h00001111222233334444;

  trivium_ctrl #(.WARMUP_CYC(WARM)) dut (
    .clk_i      (clk_i),
    .n_rst_i    (n_rst_i),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .key_i      (key_i),
    .iv_i       (iv_i),
    .busy_o     (busy_o),
    .run_o      (run_o),
    .ld_o       (ld_o),
    .ld_dat_a_o (ld_dat_a_o),
    .ld_dat_b_o (ld_dat_b_o),
    .ld_dat_c_o (ld_dat_c_o),
    .ce_o       (ce_o),
    .t_a_i      (t_a_i),
    .t_b_i      (t_b_i),
    .t_c_i      (t_c_i),
    .ks_word_o  (ks_word_o),
    .ks_valid_o (ks_valid_o),
    .ks_ready_i (ks_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // State layout: A = s[92:0], B = s[176:93], C = s[287:177]; index k is Trivium s_(k+1).
  function automatic logic trv_z(input logic [287:0] s);
    return s[65] ^ s[92] ^ s[161] ^ s[176] ^ s[242] ^ s[287];
  endfunction

  function automatic logic [287:0] trv_step(input logic [287:0] s);
    logic t1, t2, t3;
    t1 = s[65] ^ s[92] ^ (s[90] & s[91]) ^ s[170];
    t2 = s[161] ^ s[176] ^ (s[174] & s[175]) ^ s[263];
    t3 = s[242] ^ s[287] ^ (s[285] & s[286]) ^ s[68];
    return {s[286:177], t2, s[175:93], t1, s[91:0], t3};
  endfunction

  // Register model driven by the DUT's load strobes and shift enable.
  always @(posedge clk_i) begin
    if (ld_o[0]) core_s <= {3'b111, 108'h0, 52'h0, ld_dat_b_o, 61'h0, ld_dat_a_o};
    else if (ld_o[1]) begin
      core_s[63:32]   <= ld_dat_a_o;
      core_s[156:125] <= ld_dat_b_o;
    end else if (ld_o[2]) begin
      core_s[79:64]   <= ld_dat_a_o[15:0];
      core_s[172:157] <= ld_dat_b_o[15:0];
    end else if (ce_o) core_s <= trv_step(core_s);
  end

  assign t_a_i = core_s[65] ^ core_s[92];
  assign t_b_i = core_s[161] ^ core_s[176];
  assign t_c_i = core_s[242] ^ core_s[287];

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference keystream: first 128 bits after warm-up, packed LSB-first.
  task automatic gen_ref(input logic [79:0] k, input logic [79:0] v);
    logic [287:0] s;
    s = {3'b111, 108'h0, 4'h0, v, 13'h0, k};
    for (int i = 0; i < int'(WARM) + 128; i++) begin
      if (i >= int'(WARM)) ref_ks[(i - int'(WARM)) / 32][(i - int'(WARM)) % 32] = trv_z(s);
      s = trv_step(s);
    end
  endtask

  task automatic do_start(input logic [79:0] k, input logic [79:0] v, input logic with_stop);
    key_i   = k;
    iv_i    = v;
    start_i = 1'b1;
    stop_i  = with_stop;
    @(negedge clk_i);
    start_i = 1'b0;
    stop_i  = 1'b0;
    cyc     = 1;
  endtask

  task automatic check_load(input logic [31:0] a0, a1, a2, b0, b1, b2);
    check("ld0", ld_o, 3'b001);
    check("lda0", ld_dat_a_o, a0);
    check("ldb0", ld_dat_b_o, b0);
    check("ldc0", ld_dat_c_o, 32'h0);
    check("ce_load", ce_o, 1'b0);
    check("busy_load", busy_o, 1'b1);
    @(negedge clk_i); cyc++;
    check("ld1", ld_o, 3'b010);
    check("lda1", ld_dat_a_o, a1);
    check("ldb1", ld_dat_b_o, b1);
    @(negedge clk_i); cyc++;
    check("ld2", ld_o, 3'b100);
    check("lda2", ld_dat_a_o, a2);
    check("ldb2", ld_dat_b_o, b2);
    check("ce_load2", ce_o, 1'b0);
  endtask

  // Counts WARM shift cycles until RUN, then waits for the first word.
  task automatic warm_and_first(input string tag);
    int n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_i); cyc++;
      if (busy_o && ce_o) n++;
      if (run_o) break;
    end
    check({tag, "_warm_cnt"}, n, WARM);
    check({tag, "_run_cyc"}, cyc, 1156);
    for (int i = 0; i < 200; i++) begin
      if (ks_valid_o) break;
      @(negedge clk_i); cyc++;
    end
    check({tag, "_valid_cyc"}, cyc, 1188);
    check({tag, "_w0"}, ks_word_o, ref_ks[0]);
  endtask

  task automatic wait_word(output int d);
    d = 0;
    do begin
      @(negedge clk_i); cyc++; d++;
    end while (!ks_valid_o && d < 100);
  endtask

  initial begin
    int   d, n, nce;
    logic ok;
    core_s     = '0;
    n_rst_i    = 1'b0;
    start_i    = 1'b0;
    stop_i     = 1'b0;
    key_i      = '0;
    iv_i       = '0;
    ks_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_busy", busy_o, 1'b0);
    check("rst_run", run_o, 1'b0);
    check("rst_ld", ld_o, 3'b000);
    check("rst_ce", ce_o, 1'b0);
    check("rst_valid", ks_valid_o, 1'b0);
    check("rst_word", ks_word_o, 32'h0);
    n_rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("idle_ce", ce_o, 1'b0);

    // All-zero key/IV, consumer always ready.
    gen_ref(80'h0, 80'h0);
    do_start(80'h0, 80'h0, 1'b0);
    check_load(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    warm_and_first("zero");
    wait_word(d);
    check("zero_w1_gap", d, 32);
    check("zero_w1", ks_word_o, ref_ks[1]);

    // Start in WARM restarts with the new key.
    do_start(Key2, Iv2, 1'b0);
    check_load(32'hCDEF0011, 32'h456789AB, 32'h00000123,
               32'h32100022, 32'hBA987654, 32'h0000FEDC);
    n = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_i);
      if (busy_o && ce_o) n++;
      if (n == 500) break;
    end
    check("warm500", n, 500);
    gen_ref(Key3, Iv3);
    do_start(Key3, Iv3, 1'b0);
    check_load(Key3[31:0], Key3[63:32], {16'h0, Key3[79:64]},
               Iv3[31:0], Iv3[63:32], {16'h0, Iv3[79:64]});
    warm_and_first("restart");
    wait_word(d);
    check("k3_w1_gap", d, 32);
    check("k3_w1", ks_word_o, ref_ks[1]);

    // Backpressure: word 1 pending for 100 cycles; word 2 stalls on its last bit.
    ks_ready_i = 1'b0;
    ok  = 1'b1;
    nce = 0;
    for (int i = 0; i < 100; i++) begin
      if (ce_o) nce++;
      if (!ks_valid_o || ks_word_o !== ref_ks[1]) ok = 1'b0;
      @(negedge clk_i); cyc++;
    end
    check("hold_stable", ok, 1'b1);
    check("hold_bits", nce, 31);
    check("stall_ce", ce_o, 1'b0);
    check("stall_run", run_o, 1'b1);
    ks_ready_i = 1'b1;
    #1;
    check("unstall_ce", ce_o, 1'b1);
    @(negedge clk_i); cyc++;
    check("w2_valid", ks_valid_o, 1'b1);
    check("k3_w2", ks_word_o, ref_ks[2]);
    wait_word(d);
    check("k3_w3_gap", d, 32);
    check("k3_w3", ks_word_o, ref_ks[3]);

    // Stop in RUN with a pending word.
    ks_ready_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check("pre_stop_valid", ks_valid_o, 1'b1);
    stop_i = 1'b1;
    @(negedge clk_i);
    stop_i = 1'b0;
    check("stop_valid", ks_valid_o, 1'b0);
    check("stop_ce", ce_o, 1'b0);
    check("stop_run", run_o, 1'b0);
    check("stop_busy", busy_o, 1'b0);
    check("stop_ld", ld_o, 3'b000);

    // Start coincident with stop enters LOAD.
    ks_ready_i = 1'b1;
    gen_ref(Key2, Iv2);
    do_start(Key2, Iv2, 1'b1);
    check_load(32'hCDEF0011, 32'h456789AB, 32'h00000123,
               32'h32100022, 32'hBA987654, 32'h0000FEDC);
    warm_and_first("startstop");

    // Asynchronous reset mid-RUN.
    repeat (10) @(negedge clk_i);
    #2 n_rst_i = 1'b0;
    #1;
    check("arst_run", run_o, 1'b0);
    check("arst_ce", ce_o, 1'b0);
    check("arst_ld", ld_o, 3'b000);
    check("arst_valid", ks_valid_o, 1'b0);
    check("arst_word", ks_word_o, 32'h0);
    check("arst_busy", busy_o, 1'b0);
    @(negedge clk_i);
    n_rst_i = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (ce_o || ld_o != 3'b000 || busy_o || run_o || ks_valid_o) ok = 1'b0;
    end
    check("post_rst_quiet", ok, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/trivium_ctrl.md
# trivium_ctrl

Sequencer for one Trivium keystream core built from three feedback shift registers: A (93 bits), B (84 bits) and C (111 bits). It latches an 80-bit key and an 80-bit IV, loads them into the registers over the 32-bit load ports, and runs the warm-up rotations. It then clocks the registers on demand and packs the keystream bits into 32-bit words for the UART cipher datapath, using a valid/ready handshake.

## Interface
- WARMUP_CYC, 1152, number of register clocks in the warm-up phase (4×288); legal range 1..2047
- clk_i  in  1  clock
- n_rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  single-cycle pulse; latch key/IV and (re)start the sequence
- stop_i  in  1  single-cycle pulse; abort to IDLE
- key_i  in  80  key, sampled on an accepted start_i
- iv_i  in  80  IV, sampled on an accepted start_i
- busy_o  out  1  high in LOAD and WARM
- run_o  out  1  high in RUN
- ld_o  out  3  one-hot load strobe, shared by A/B/C (bit0=[31:0], bit1=[63:32], bit2=[79:64])
- ld_dat_a_o  out  32  key slice for register A
- ld_dat_b_o  out  32  IV slice for register B
- ld_dat_c_o  out  32  constant 0 for register C
- ce_o  out  1  shift enable, shared by all three registers
- t_a_i, t_b_i, t_c_i  in  1 each  keystream terms from the registers (combinational from current state)
- ks_word_o  out  32  keystream word
- ks_valid_o  out  1  ks_word_o valid
- ks_ready_i  in  1  consumer accepts the word

## Operation
- States: IDLE → LOAD → WARM → RUN. stop_i in any state → IDLE.
- start_i is accepted in any state. It latches key_i/iv_i, clears the bit counter and the output buffer (ks_valid_o←0), and enters LOAD. start_i takes priority over stop_i in the same cycle.
- LOAD: exactly 3 cycles with idx 0,1,2.
  - ld_o = 3'b001, 3'b010, 3'b100 in turn.
  - ld_dat_a_o = key[31:0], key[63:32], {16'h0, key[79:64]}.
  - ld_dat_b_o = the matching IV slices.
  - ld_dat_c_o = 0. Register C sets its own top 3 bits.
  - ce_o = 0 throughout LOAD.
- WARM: ce_o = 1 for exactly WARMUP_CYC cycles. An 11-bit down-counter is loaded with WARMUP_CYC−1. Terms are ignored. The state moves to RUN when the counter is 0 and ce_o = 1.
- RUN:
  - z = t_a_i ^ t_b_i ^ t_c_i, sampled in every cycle where ce_o = 1 (the pre-shift state).
  - Bits pack LSB-first into a 32-bit shift buffer with a 5-bit counter.
  - When the 32nd bit is taken, the full word (including that bit) moves to the ks_word_o register and ks_valid_o = 1.
  - ce_o = run_o & ~(bit_cnt==31 & ks_valid_o & ~ks_ready_i). Packing of the next word therefore overlaps a pending output, and the stall occurs only on the final bit.
  - When bit_cnt==31, ks_valid_o & ks_ready_i and ce_o are all 1 in the same cycle, the new word is loaded and ks_valid_o stays 1.
- Handshake: ks_word_o and ks_valid_o are held stable while ks_valid_o & ~ks_ready_i. ks_valid_o falls after acceptance unless a new word is loaded in that cycle.
- In IDLE, and after stop_i, ld_o = 0, ce_o = 0 and ks_valid_o = 0. A partially packed word is discarded.

## Timing
- Reset value of every output is 0. State is IDLE, counters are 0 and the key/IV latches are 0.
- Reset asserted mid-operation: outputs go to 0 immediately (asynchronous). No load or shift occurs after reset deasserts until a new start_i.
- Let edge E0 be the edge that samples start_i.
- LOAD strobes are valid in the cycles after E0, E1 and E2.
- ce_o is high in the cycles after E3 through E(2+WARMUP_CYC).
- For the default WARMUP_CYC, the first RUN ce_o cycle follows E1155. ks_valid_o rises after E1187, i.e. 1188 cycles after E0 with no stalls.
- Steady state with ks_ready_i tied 1: one word every 32 cycles, with no bubble.

## Structure
- The shared package trivium_pkg holds:
  - the state enum (IDLE, LOAD, WARM, RUN);
  - KS_WORD_W = 32 and KEY_W = IV_W = 80;
  - the one-hot load constants LD_W0/LD_W1/LD_W2;
  - the register lengths 93/84/111.
- One sub-module, trivium_ks_packer, holds the shift buffer, the bit counter, the output register and the stall logic. It is driven by a bit-valid signal and clear.

## Test plan
- Key = 80'h0, IV = 80'h0, WARMUP_CYC = 1152, ks_ready_i = 1 → ld_o sequence 1,2,4 with data 0; exactly 1152 WARM ce cycles; first ks_word_o equals the golden model's first 32 bits (LSB = first bit); valid after 1188 cycles.
- Key = 80'h0123456789ABCDEF0011, IV = 80'hFEDCBA98765432100022 → ld_dat_a_o = 32'h00110123? No, slices are LSB-first: 32'hCDEF0011, 32'h456789AB, 32'h00000123. ld_dat_b_o = 32'h32100022, 32'hBA987654, 32'h0000FEDC.
- ks_ready_i held 0 for 100 cycles after the first word → second word packs 31 bits, ce_o drops at bit_cnt==31, and ks_word_o stays stable. On ks_ready_i=1, the second word appears the next cycle with no lost bit versus the model.
- start_i pulse in WARM at cycle 500 → returns to LOAD with the new key, and 1152 fresh WARM cycles follow. start_i coincident with stop_i → LOAD.
- stop_i in RUN with ks_valid_o=1 → ks_valid_o=0 and ce_o=0 the next cycle, then IDLE.
- n_rst_i pulsed low mid-RUN → all outputs 0 asynchronously; no ce_o or ld_o until the next start_i.
